// File: rtl/tia_axil_pkg.sv
// Shared register map, STATUS layout and timer states for the TIA block.
// Imported by tia_axil_slave and tia_settle_timer.
package tia_axil_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_SETTLE = 5'h04;
  localparam logic [4:0] OFF_SCR0   = 5'h08;
  localparam logic [4:0] OFF_SCR1   = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam logic [2:0] W_CTRL   = OFF_CTRL[4:2];
  localparam logic [2:0] W_SETTLE = OFF_SETTLE[4:2];
  localparam logic [2:0] W_SCR0   = OFF_SCR0[4:2];
  localparam logic [2:0] W_SCR1   = OFF_SCR1[4:2];
  localparam logic [2:0] W_STATUS = OFF_STATUS[4:2];

  localparam int unsigned STAT_BUSY_BIT = 31;
  localparam int unsigned STAT_DONE_BIT = 30;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FIRE,
    ST_WAIT
  } tia_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{s[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tia_settle_timer.sv
// Settle timer: IDLE -> SETTLE -> FIRE -> WAIT -> IDLE, latches ADC sample.
// Ports: clk_i/rst_ni, start_i/abort_i/settle_i, adc_*_i, start_o/busy_o/done_o/sample_o.
module tia_settle_timer
  import tia_axil_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] settle_i,
  input  logic [15:0] adc_data_i,
  input  logic        adc_valid_i,
  output logic        start_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] sample_o
);

  tia_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] sample_q, sample_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      sample_q <= sample_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    sample_d = sample_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETTLE;
          cnt_d   = settle_i;
          done_d  = 1'b0;
        end
      end
      // Leave when the decremented count hits 0; a load of 0 or 1
      // still spends one cycle here.
      ST_SETTLE: begin
        if (cnt_q <= 16'd1) begin
          state_d = ST_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (adc_valid_i) begin
          sample_d = adc_data_i;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything and keeps done as it was.
    if (abort_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      done_d   = done_q;
      sample_d = sample_q;
    end
  end

  assign start_o  = (state_q == ST_FIRE);
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign sample_o = sample_q;

endmodule

// File: rtl/tia_axil_slave.sv
// AXI4-Lite register slave for a TIA front end (CTRL/SETTLE/SCRATCH/STATUS).
// Ports: s00_axi_* AXI-Lite slave, tia_* analog control; TIA_AXIL_WSTRB_EN enables byte strobes.
module tia_axil_slave
  import tia_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [3:0]                        tia_gain_sel,
  output logic                              tia_start,
  output logic                              tia_busy,
  input  logic [15:0]                       tia_adc_data,
  input  logic                              tia_adc_valid
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic [2:0]    waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          bvalid_q, bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] settle_q, settle_d;
  logic [DW-1:0] scr0_q, scr0_d;
  logic [DW-1:0] scr1_q, scr1_d;

  logic          commit;
  logic          wr_ctrl;
  logic          strb0;
  logic [DW-1:0] wmask;
  logic [DW-1:0] status;
  logic [DW-1:0] rmux;
  logic          t_busy;
  logic          t_done;
  logic [15:0]   t_sample;
  logic          unused_ok;

`ifdef TIA_AXIL_WSTRB_EN
  logic [(DW/8)-1:0] wstrb_q;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wstrb_q <= '0;
    end else if (wready_q && s00_axi_wvalid) begin
      wstrb_q <= s00_axi_wstrb;
    end
  end

  assign wmask = strb_mask(wstrb_q);
  assign strb0 = wstrb_q[0];
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
  assign wmask = '1;
  assign strb0 = 1'b1;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`endif

  // Both halves held: the write lands this cycle.
  assign commit  = aw_held_q && w_held_q;
  assign wr_ctrl = commit && (waddr_q == W_CTRL);

  assign status = {t_busy, t_done, 14'b0, t_sample};

  always_comb begin
    rmux = '0;
    unique case (s00_axi_araddr[4:2])
      W_CTRL:   rmux = ctrl_q;
      W_SETTLE: rmux = settle_q;
      W_SCR0:   rmux = scr0_q;
      W_SCR1:   rmux = scr1_q;
      W_STATUS: rmux = status;
      default:  rmux = '0;
    endcase
  end

  always_comb begin
    awready_d = s00_axi_awvalid && !awready_q && !aw_held_q && !bvalid_q;
    wready_d  = s00_axi_wvalid && !wready_q && !w_held_q && !bvalid_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    arready_d = s00_axi_arvalid && !arready_q && !rvalid_q && !commit;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    settle_d  = settle_q;
    scr0_d    = scr0_q;
    scr1_d    = scr1_q;

    if (awready_q && s00_axi_awvalid) begin
      aw_held_d = 1'b1;
      waddr_d   = s00_axi_awaddr[4:2];
    end
    if (wready_q && s00_axi_wvalid) begin
      w_held_d = 1'b1;
      wdata_d  = s00_axi_wdata;
    end

    // Start bit only lives for the commit cycle.
    ctrl_d[CTRL_START_BIT] = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      unique case (waddr_q)
        W_CTRL:   ctrl_d   = (ctrl_q & ~wmask) | (wdata_q & wmask);
        W_SETTLE: settle_d = (settle_q & ~wmask) | (wdata_q & wmask);
        W_SCR0:   scr0_d   = (scr0_q & ~wmask) | (wdata_q & wmask);
        W_SCR1:   scr1_d   = (scr1_q & ~wmask) | (wdata_q & wmask);
        default: ;
      endcase
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (arready_q && s00_axi_arvalid) begin
      rvalid_d = 1'b1;
      rdata_d  = rmux;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      settle_q  <= '0;
      scr0_q    <= '0;
      scr1_q    <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      settle_q  <= settle_d;
      scr0_q    <= scr0_d;
      scr1_q    <= scr1_d;
    end
  end

  tia_settle_timer u_timer (
    .clk_i       (s00_axi_aclk),
    .rst_ni      (s00_axi_aresetn),
    .start_i     (wr_ctrl && strb0 && wdata_q[CTRL_START_BIT]),
    .abort_i     (wr_ctrl && strb0 && wdata_q[CTRL_ABORT_BIT]),
    .settle_i    (settle_q[15:0]),
    .adc_data_i  (tia_adc_data),
    .adc_valid_i (tia_adc_valid),
    .start_o     (tia_start),
    .busy_o      (t_busy),
    .done_o      (t_done),
    .sample_o    (t_sample)
  );

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;
  assign tia_gain_sel    = ctrl_q[7:4];
  assign tia_busy        = t_busy;

endmodule

// File: tb/tb_tia_axil_slave.sv
// Self-checking bench for tia_axil_slave: vector table plus timer/reset sequences.
// Reads push expected data on a scoreboard queue, popped when rvalid arrives.
module tb_tia_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  gain_sel;
  logic        tstart;
  logic        tbusy;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;

  always #5 clk = ~clk;

  tia_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .tia_gain_sel    (gain_sel),
    .tia_start       (tstart),
    .tia_busy        (tbusy),
    .tia_adc_data    (adc_data),
    .tia_adc_valid   (adc_valid)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  int   cyc = 0;
  int   bv_rises = 0;
  int   bv_cyc = 0;
  int   st_pulses = 0;
  int   st_cyc = 0;
  logic bv_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bvalid && !bv_prev) begin
      bv_rises++;
      bv_cyc = cyc;
    end
    if (tstart) begin
      st_pulses++;
      st_cyc = cyc;
    end
    bv_prev = bvalid;
  end

  logic [31:0] sb_q[$];
  string       sbn_q[$];

  function automatic logic [63:0] all_outs();
    return {17'b0, awready, wready, bvalid, bresp, arready, rvalid,
            rresp, rdata, gain_sel, tstart, tbusy};
  endfunction

  // bhold < 0 leaves the response pending (bready never raised).
  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int wlead,
                        input int bhold);
    bit aw_hs;
    bit w_hs;
    int n;
    aw_hs = 0;
    w_hs = 0;
    n = 0;
    awaddr = a;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    if (wlead == 0) awvalid = 1'b1;
    while (!(aw_hs && w_hs) && n < 40) begin
      @(negedge clk);
      if (awvalid && awready) aw_hs = 1;
      if (wvalid && wready) w_hs = 1;
      @(posedge clk);
      #1;
      n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      if (!aw_hs && n >= wlead) awvalid = 1'b1;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (!(aw_hs && w_hs)) chk("aw_w_timeout", 0, 1);
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", bvalid, 1);
    chk("bresp", bresp, 0);
    if (bhold < 0) return;
    for (int i = 0; i < bhold; i++) begin
      chk("bvalid_hold", bvalid, 1);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    if (bhold > 0) chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic axi_rd(input logic [4:0] a, input logic [31:0] exp,
                        input string nm);
    int n;
    bit hs;
    logic [31:0] e;
    string en;
    sb_q.push_back(exp);
    sbn_q.push_back(nm);
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    hs = 0;
    while (!hs && n < 40) begin
      @(negedge clk);
      if (arready) hs = 1;
      @(posedge clk);
      #1;
      n++;
    end
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    en = sbn_q.pop_front();
    if (!rvalid) begin
      chk({en, "_timeout"}, 0, 1);
    end else begin
      chk(en, rdata, e);
      chk({en, "_rresp"}, rresp, 0);
    end
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int p0;
    int r0;
    logic [31:0] mrg;

`ifdef TIA_AXIL_WSTRB_EN
    mrg = 32'hAABB3344;
`else
    mrg = 32'h11223344;
`endif
    tbl.push_back('{1, 5'h00, 32'h1, 4'hF, 32'h0});
    tbl.push_back('{1, 5'h04, 32'h2, 4'hF, 32'h0});
    tbl.push_back('{1, 5'h08, 32'h3, 4'hF, 32'h0});
    tbl.push_back('{1, 5'h0C, 32'h4, 4'hF, 32'h0});
    tbl.push_back('{0, 5'h00, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{0, 5'h04, 32'h0, 4'h0, 32'h2});
    tbl.push_back('{0, 5'h08, 32'h0, 4'h0, 32'h3});
    tbl.push_back('{0, 5'h0C, 32'h0, 4'h0, 32'h4});
    tbl.push_back('{0, 5'h10, 32'h0, 4'h0, 32'h80000000});
    tbl.push_back('{1, 5'h14, 32'hDEADBEEF, 4'hF, 32'h0});
    tbl.push_back('{0, 5'h14, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{0, 5'h1C, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1, 5'h00, 32'h2, 4'hF, 32'h0});
    tbl.push_back('{0, 5'h10, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{0, 5'h00, 32'h0, 4'h0, 32'h2});
    tbl.push_back('{1, 5'h08, 32'hAABBCCDD, 4'hF, 32'h0});
    tbl.push_back('{1, 5'h08, 32'h11223344, 4'h3, 32'h0});
    tbl.push_back('{0, 5'h08, 32'h0, 4'h0, mrg});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outs", all_outs(), 0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) axi_wr(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0);
      else axi_rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl[%0d]", i));
    end

    // Settle timing and ADC capture.
    axi_wr(5'h04, 32'd5, 4'hF, 0, 0);
    p0 = st_pulses;
    axi_wr(5'h00, 32'h31, 4'hF, 0, 0);
    chk("gain_sel", gain_sel, 3);
    chk("busy_settle", tbusy, 1);
    repeat (8) @(negedge clk);
    chk("start_pulses", st_pulses - p0, 1);
    chk("start_delay", st_cyc - bv_cyc, 5);
    chk("busy_wait", tbusy, 1);
    adc_data = 16'hBEEF;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    chk("busy_done", tbusy, 0);
    axi_rd(5'h10, 32'h4000BEEF, "status_done");
    adc_data = 16'h1234;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    axi_rd(5'h10, 32'h4000BEEF, "status_idle_adc");

    // Abort keeps done (cleared by the start just before).
    axi_wr(5'h04, 32'd50, 4'hF, 0, 0);
    axi_wr(5'h00, 32'h1, 4'hF, 0, 0);
    chk("busy_before_abort", tbusy, 1);
    axi_wr(5'h00, 32'h2, 4'hF, 0, 0);
    chk("busy_after_abort", tbusy, 0);
    axi_rd(5'h10, 32'h0000BEEF, "status_abort");

    // W leads AW by 3 cycles, bready held low for 4 cycles.
    r0 = bv_rises;
    axi_wr(5'h0C, 32'hCAFEF00D, 4'hF, 3, 4);
    chk("single_commit", bv_rises - r0, 1);
    axi_rd(5'h0C, 32'hCAFEF00D, "scr1_lead");

    // Reset while settling.
    axi_wr(5'h04, 32'd100, 4'hF, 0, 0);
    axi_wr(5'h00, 32'h1, 4'hF, 0, 0);
    chk("busy_pre_rst", tbusy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_settle_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_settle_outs", all_outs(), 0);

    // Reset with a response still pending.
    axi_wr(5'h08, 32'h55, 4'hF, 0, -1);
    rst_n = 1'b0;
    #1;
    chk("rst_bvalid_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rel_bvalid_outs", all_outs(), 0);
    axi_rd(5'h08, 32'h0, "scr0_after_rst");
    axi_rd(5'h10, 32'h0, "status_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
